// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: circular fetch-to-decoder instruction queue with ROB/RS/LSB-gated dispatch and flush.
module issue_queue_ctrl #(
  parameter int IQ_DEPTH_LOG = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    if_valid,
  input  logic [ADDR_WIDTH-1:0]   if_pc,
  input  logic [INST_WIDTH-1:0]   if_inst,
  output logic                    iq_full,
  output logic [IQ_DEPTH_LOG:0]   iq_count,
  input  logic                    rob_full,
  input  logic                    rs_full,
  input  logic                    lsb_full,
  output logic                    if2dec,
  output logic [ADDR_WIDTH-1:0]   dec_pc,
  output logic [INST_WIDTH-1:0]   dec_inst,
  output logic                    dec_to_lsb
);
  localparam int DEPTH = 1 << IQ_DEPTH_LOG;
  typedef enum logic {S_RUN, S_FLUSH} state_t;
  state_t state;
  logic [IQ_DEPTH_LOG:0] head, tail;
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [IQ_DEPTH_LOG-1:0] hi, ti;
  logic empty, head_lsb, live, push, pop;
  assign hi = head[IQ_DEPTH_LOG-1:0];
  assign ti = tail[IQ_DEPTH_LOG-1:0];
  assign empty = head == tail;
  assign iq_full = hi == ti && head[IQ_DEPTH_LOG] != tail[IQ_DEPTH_LOG];
  assign iq_count = tail - head;
  // Loads and stores go to the LSB; everything else, illegal opcodes included, to the RS.
  assign head_lsb = inst_q[hi][6:0] == 7'b0000011 || inst_q[hi][6:0] == 7'b0100011;
  assign live = state == S_RUN && !flush;
  assign push = live && if_valid && !iq_full;
  assign pop = live && !empty && !rob_full && (head_lsb ? !lsb_full : !rs_full);
  always_ff @(posedge clk)
    if (rdy_in && push) begin
      pc_q[ti] <= if_pc;
      inst_q[ti] <= if_inst;
    end
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      head <= '0;
      tail <= '0;
      state <= S_RUN;
      if2dec <= 1'b0;
      dec_pc <= '0;
      dec_inst <= '0;
      dec_to_lsb <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        if2dec <= 1'b0;
        state <= S_FLUSH;
      end else if (state == S_FLUSH) begin
        if2dec <= 1'b0;
        state <= S_RUN;
      end else begin
        if2dec <= pop;
        if (pop) begin
          dec_pc <= pc_q[hi];
          dec_inst <= inst_q[hi];
          dec_to_lsb <= head_lsb;
          head <= head + 1'b1;
        end
        if (push) tail <= tail + 1'b1;
      end
    end
endmodule

// File: tb/tb_issue_queue_ctrl.sv
// tb_issue_queue_ctrl: scoreboard bench; accepted offers are queued, each dispatch pops and compares.
module tb_issue_queue_ctrl;
  logic clk = 1'b0;
  logic rst_in, rdy_in, flush, if_valid, rob_full, rs_full, lsb_full;
  logic [31:0] if_pc, if_inst;
  logic iq_full, if2dec, dec_to_lsb;
  logic [3:0] iq_count;
  logic [31:0] dec_pc, dec_inst;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t sb[$];
  logic m_fl, e_v, e_lsb, acc;
  logic [31:0] e_pc, e_inst;
  int errors = 0;
  int checks = 0;

  issue_queue_ctrl dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .iq_full(iq_full), .iq_count(iq_count),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .if2dec(if2dec), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_to_lsb(dec_to_lsb)
  );

  always #5 clk = ~clk;

  function automatic logic is_lsb(logic [31:0] i);
    return i[6:0] == 7'b0000011 || i[6:0] == 7'b0100011;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_fl = 1'b0;
    e_v = 1'b0;
    e_pc = '0;
    e_inst = '0;
    e_lsb = 1'b0;
  endtask

  // One clock: predict from pre-edge state, advance the model at the edge, compare at the falling edge.
  task automatic cyc();
    logic live, push, pop;
    ent_t h;
    live = rst_in && rdy_in;
    push = live && !flush && !m_fl && if_valid && sb.size() < 8;
    pop = 1'b0;
    if (live && !flush && !m_fl && sb.size() > 0)
      pop = !rob_full && (is_lsb(sb[0].inst) ? !lsb_full : !rs_full);
    @(posedge clk);
    if (live) begin
      if (flush) begin
        sb.delete();
        m_fl = 1'b1;
        e_v = 1'b0;
      end else if (m_fl) begin
        m_fl = 1'b0;
        e_v = 1'b0;
      end else begin
        e_v = pop;
        if (pop) begin
          h = sb.pop_front();
          e_pc = h.pc;
          e_inst = h.inst;
          e_lsb = is_lsb(h.inst);
        end
        if (push) sb.push_back({if_pc, if_inst});
      end
    end
    acc = push;
    @(negedge clk);
    checks++;
    if (if2dec !== e_v) begin
      errors++;
      $display("FAIL if2dec: got %b expected %b at %0t", if2dec, e_v, $time);
    end
    if (e_v) begin
      checks++;
      if ({dec_pc, dec_inst, dec_to_lsb} !== {e_pc, e_inst, e_lsb}) begin
        errors++;
        $display("FAIL dispatch: got pc=%h inst=%h lsb=%b expected pc=%h inst=%h lsb=%b",
                 dec_pc, dec_inst, dec_to_lsb, e_pc, e_inst, e_lsb);
      end
    end
    checks++;
    if (iq_count !== 4'(sb.size()) || iq_full !== (sb.size() == 8)) begin
      errors++;
      $display("FAIL occupancy: got count=%0d full=%b expected count=%0d", iq_count, iq_full, sb.size());
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc = pc;
    if_inst = inst;
    cyc();
    if_valid = 1'b0;
  endtask

  task automatic drain();
    rob_full = 1'b0;
    rs_full = 1'b0;
    lsb_full = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({if2dec, dec_pc, dec_inst, dec_to_lsb, iq_count, iq_full} !== '0) begin
      errors++;
      $display("FAIL reset_state: if2dec=%b pc=%h inst=%h count=%0d", if2dec, dec_pc, dec_inst, iq_count);
    end
    @(negedge clk);
    rst_in = 1'b1;
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) offer(32'h200 + 32'(4 * i), 32'h00000013);
    rob_full = 1'b0;
    cyc();
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({if2dec, dec_pc, dec_inst, dec_to_lsb, iq_count, iq_full} !== '0) begin
      errors++;
      $display("FAIL async_reset: if2dec=%b pc=%h inst=%h count=%0d", if2dec, dec_pc, dec_inst, iq_count);
    end
    @(negedge clk);
    cyc();
    rst_in = 1'b1;
    offer(32'h0, 32'h00000013);
    checks++;
    if (if2dec !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: if2dec=%b expected 0", if2dec);
    end
    cyc();
    checks++;
    if (if2dec !== 1'b1 || dec_to_lsb !== 1'b0 || dec_pc !== 32'h0) begin
      errors++;
      $display("FAIL first_dispatch: if2dec=%b lsb=%b pc=%h expected 1 0 0", if2dec, dec_to_lsb, dec_pc);
    end
    cyc();
  endtask

  task automatic test_fill_wrap();
    logic [31:0] pc;
    rob_full = 1'b1;
    rs_full = 1'b1;
    lsb_full = 1'b1;
    for (int i = 0; i < 8; i++) offer(32'(4 * i), 32'h00000013);
    checks++;
    if (iq_full !== 1'b1 || iq_count !== 4'd8) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d expected 1 8", iq_full, iq_count);
    end
    offer(32'h20, 32'h00000013);
    checks++;
    if (acc !== 1'b0 || iq_count !== 4'd8) begin
      errors++;
      $display("FAIL ninth_offer: count=%0d expected 8", iq_count);
    end
    rob_full = 1'b0;
    rs_full = 1'b0;
    lsb_full = 1'b0;
    pc = 32'h20;
    for (int i = 0; i < 30 && pc <= 32'h4C; i++) begin
      offer(pc, 32'h00000013);
      if (acc) pc += 4;
    end
    checks++;
    if (pc !== 32'h50) begin
      errors++;
      $display("FAIL wrap_pushes: next pc=%h expected 00000050", pc);
    end
    drain();
  endtask

  task automatic test_routing();
    rob_full = 1'b1;
    offer(32'h100, 32'h00002083);
    offer(32'h104, 32'h002081B3);
    rob_full = 1'b0;
    lsb_full = 1'b1;
    cyc();
    cyc();
    checks++;
    if (if2dec !== 1'b0 || iq_count !== 4'd2) begin
      errors++;
      $display("FAIL head_block: if2dec=%b count=%0d expected 0 2", if2dec, iq_count);
    end
    lsb_full = 1'b0;
    cyc();
    checks++;
    if (if2dec !== 1'b1 || dec_to_lsb !== 1'b1 || dec_pc !== 32'h100) begin
      errors++;
      $display("FAIL route_lsb: if2dec=%b lsb=%b pc=%h expected 1 1 00000100", if2dec, dec_to_lsb, dec_pc);
    end
    cyc();
    checks++;
    if (if2dec !== 1'b1 || dec_to_lsb !== 1'b0 || dec_pc !== 32'h104) begin
      errors++;
      $display("FAIL route_rs: if2dec=%b lsb=%b pc=%h expected 1 0 00000104", if2dec, dec_to_lsb, dec_pc);
    end
    rob_full = 1'b1;
    offer(32'h108, 32'h00002083);
    offer(32'h10C, 32'h002081B3);
    cyc();
    checks++;
    if (if2dec !== 1'b0 || iq_count !== 4'd2) begin
      errors++;
      $display("FAIL rob_block: if2dec=%b count=%0d expected 0 2", if2dec, iq_count);
    end
    drain();
  endtask

  task automatic test_flush();
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) offer(32'h300 + 32'(4 * i), 32'h00000013);
    flush = 1'b1;
    offer(32'h400, 32'h00000013);
    flush = 1'b0;
    checks++;
    if (iq_count !== 4'd0 || if2dec !== 1'b0) begin
      errors++;
      $display("FAIL flush: count=%0d if2dec=%b expected 0 0", iq_count, if2dec);
    end
    offer(32'h404, 32'h00000013);
    checks++;
    if (iq_count !== 4'd0) begin
      errors++;
      $display("FAIL flush_state: count=%0d expected 0", iq_count);
    end
    offer(32'h408, 32'h00000013);
    checks++;
    if (iq_count !== 4'd1) begin
      errors++;
      $display("FAIL post_flush_push: count=%0d expected 1", iq_count);
    end
    drain();
  endtask

  task automatic test_freeze();
    logic [3:0] c;
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) offer(32'h500 + 32'(4 * i), 32'h00000013);
    rob_full = 1'b0;
    cyc();
    c = iq_count;
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush = i[0];
      offer(32'h600, 32'h00000013);
      checks++;
      if (iq_count !== c || if2dec !== 1'b1) begin
        errors++;
        $display("FAIL freeze: count=%0d if2dec=%b expected %0d 1", iq_count, if2dec, c);
      end
    end
    flush = 1'b0;
    rdy_in = 1'b1;
    drain();
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    flush = 1'b0;
    if_valid = 1'b0;
    if_pc = '0;
    if_inst = '0;
    rob_full = 1'b0;
    rs_full = 1'b0;
    lsb_full = 1'b0;
    model_reset();
    test_reset();
    test_fill_wrap();
    test_routing();
    test_flush();
    test_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
